// File: rtl/usb_cdc_serial_state_notify.sv
// -----------------------------------------------------------------------------
// usb_cdc_serial_state_notify
//
// Device-to-host half of the CDC-ACM control path. Collects UART line levels
// and one-shot error/ring/break events, and streams a 10-byte SERIAL_STATE
// notification (A1 20 0000 wIndex 0002 + 2-byte UART state) out of the
// interrupt-IN endpoint. While nothing is pending the cork output stays high
// so the USB controller NAKs the endpoint.
//
// Ports:
//   PHY_CLKOUT       clock
//   RESET_IN         asynchronous, active-high reset
//   uart_en_i        DTR/enable; new notifications are only raised while high
//   dcd_i, dsr_i     line levels (bRxCarrier bit0, bTxCarrier bit1)
//   brk_evt_i .. ovr_evt_i   one-cycle event pulses (bits 2..6)
//   endpt_sel        endpoint currently addressed by the USB controller
//   usb_txact        controller IN transaction active
//   usb_txpop        controller consumed the current byte
//   usb_txdat_len_o  fixed packet length (10)
//   notify_dat_o     byte currently offered to the controller
//   notify_cork_o    1 = nothing to send
//   notify_busy_o    1 = snapshot armed or transfer in progress
// -----------------------------------------------------------------------------
module usb_cdc_serial_state_notify #(
  parameter logic [3:0]  ENDPT_NOTIFY  = 4'h2,
  parameter logic [15:0] INTERFACE_NUM = 16'h0
) (
  input  logic        PHY_CLKOUT,
  input  logic        RESET_IN,
  input  logic        uart_en_i,
  input  logic        dcd_i,
  input  logic        dsr_i,
  input  logic        brk_evt_i,
  input  logic        ring_evt_i,
  input  logic        frm_err_evt_i,
  input  logic        par_err_evt_i,
  input  logic        ovr_evt_i,
  input  logic [3:0]  endpt_sel,
  input  logic        usb_txact,
  input  logic        usb_txpop,
  output logic [11:0] usb_txdat_len_o,
  output logic [7:0]  notify_dat_o,
  output logic        notify_cork_o,
  output logic        notify_busy_o
);

  typedef enum logic [1:0] {IDLE, ARMED, SEND, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  dat_q, dat_d;
  logic        cork_q, cork_d;
  logic        busy_q, busy_d;
  logic [6:2]  pending_q, pending_d;
  logic        last_dcd_q, last_dcd_d;
  logic        last_dsr_q, last_dsr_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [6:0]  snap_q, snap_d;

  logic [6:2]  evt_vec;
  logic        ep_match;
  logic        pop;
  logic        trigger;

  // Only the low 7 bits of the UART state word can ever be set, so the
  // snapshot keeps just those; the high byte of the word is always zero.
  function automatic logic [7:0] byte_at(input logic [3:0] idx, input logic [6:0] snap);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = 8'hA1;
      4'd1:    b = 8'h20;
      4'd4:    b = INTERFACE_NUM[7:0];
      4'd5:    b = INTERFACE_NUM[15:8];
      4'd6:    b = 8'h02;
      4'd8:    b = {1'b0, snap};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign evt_vec  = {ovr_evt_i, par_err_evt_i, frm_err_evt_i, ring_evt_i, brk_evt_i};
  assign ep_match = usb_txact & (endpt_sel == ENDPT_NOTIFY);
  assign pop      = ep_match & usb_txpop;

  // A notification is due when any event is latched or either level differs
  // from what the host was last told.
  assign trigger = uart_en_i & ((|pending_q) | (dcd_i != last_dcd_q) | (dsr_i != last_dsr_q));

  // State and datapath registers; reset returns everything to the idle,
  // corked condition immediately, dropping any transfer in flight.
  always_ff @(posedge PHY_CLKOUT or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q    <= IDLE;
      dat_q      <= 8'h00;
      cork_q     <= 1'b1;
      busy_q     <= 1'b0;
      pending_q  <= '0;
      last_dcd_q <= 1'b0;
      last_dsr_q <= 1'b0;
      byte_idx_q <= 4'd0;
      snap_q     <= '0;
    end else begin
      state_q    <= state_d;
      dat_q      <= dat_d;
      cork_q     <= cork_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      last_dcd_q <= last_dcd_d;
      last_dsr_q <= last_dsr_d;
      byte_idx_q <= byte_idx_d;
      snap_q     <= snap_d;
    end
  end

  // Next-state logic. An aborted or short IN transaction sends us back to
  // ARMED with the same snapshot so the host can simply retry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (trigger) state_d = ARMED;
      ARMED: begin
        if (!uart_en_i)    state_d = IDLE;
        else if (ep_match) state_d = SEND;
      end
      SEND: begin
        if (!usb_txact)                    state_d = ARMED;
        else if (pop && byte_idx_q == 4'd9) state_d = DONE;
      end
      DONE:  if (!usb_txact) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs. Pending bits captured into a snapshot
  // are cleared, but an event arriving on the capture cycle is OR'd back in
  // afterwards so it survives for the next notification.
  always_comb begin
    dat_d      = dat_q;
    cork_d     = cork_q;
    busy_d     = busy_q;
    last_dcd_d = last_dcd_q;
    last_dsr_d = last_dsr_q;
    byte_idx_d = byte_idx_q;
    snap_d     = snap_q;
    pending_d  = pending_q | evt_vec;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          snap_d     = {pending_q, dsr_i, dcd_i};
          pending_d  = evt_vec;
          dat_d      = 8'hA1;
          byte_idx_d = 4'd0;
          cork_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ARMED: begin
        if (!uart_en_i) begin
          cork_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      SEND: begin
        if (!usb_txact) begin
          byte_idx_d = 4'd0;
          dat_d      = 8'hA1;
        end else if (pop) begin
          if (byte_idx_q == 4'd9) begin
            byte_idx_d = 4'd10;
            cork_d     = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            dat_d      = byte_at(byte_idx_q + 4'd1, snap_q);
          end
        end
      end
      DONE: begin
        // Levels are committed only once the host has the whole packet, so
        // any change seen during the transfer re-triggers afterwards.
        if (!usb_txact) begin
          last_dcd_d = snap_q[0];
          last_dsr_d = snap_q[1];
          busy_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign usb_txdat_len_o = 12'd10;
  assign notify_dat_o    = dat_q;
  assign notify_cork_o   = cork_q;
  assign notify_busy_o   = busy_q;

endmodule
